lcd_init_seq: RTL and testbench



---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_dly_cnt.sv | 27 ++
 rtl/lcd_init_seq.sv | 129 ++++++++++++
 tb/tb_lcd_init_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD power-up sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_FETCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4,
    ST_LWAIT    = 3'd5,
    ST_DONE     = 3'd6
  } lcd_state_e;

  localparam logic [7:0] LCD_DLY_MARKER = 8'hFF;
  localparam int         LCD_INST_NUM   = 14;
  localparam int         LCD_ADDR_W     = 4;

  // Address of the final ROM entry executed for an n-entry program.
  function automatic logic [LCD_ADDR_W-1:0] lcd_last_addr(input int n);
    return LCD_ADDR_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_dly_cnt.sv
// Loadable down-counter that saturates at zero; shared by every wait state.
module lcd_dly_cnt #(
  parameter int DLY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DLY_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: walks the instruction ROM, streams bytes over
// valid/ready and inserts power-up, inter-command and sleep-out delays.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int N_INST     = LCD_INST_NUM,
  parameter int PWR_DELAY  = 120000,
  parameter int GAP_DELAY  = 16,
  parameter int LONG_DELAY = 600000,
  parameter int DLY_W      = 24,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [LCD_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_byte,
  output logic                  busy,
  output logic                  init_done
);

  localparam logic [LCD_ADDR_W-1:0] LAST_ADDR = lcd_last_addr(N_INST);
  localparam logic [DLY_W-1:0]      PWR_LD    = DLY_W'(PWR_DELAY - 1);
  localparam logic [DLY_W-1:0]      GAP_LD    = DLY_W'(GAP_DELAY - 1);
  localparam logic [DLY_W-1:0]      LONG_LD   = DLY_W'(LONG_DELAY - 1);

  lcd_state_e            state_q;
  logic [LCD_ADDR_W-1:0] addr_q;
  logic [7:0]            byte_q;
  logic                  valid_q, busy_q, done_q;

  logic                  launch, is_marker, hs;
  logic                  cnt_load, cnt_zero;
  logic [DLY_W-1:0]      cnt_val;

  // IDLE is only ever entered from reset, so its first cycle is the
  // first post-reset cycle that auto-start keys on.
  assign launch    = ((state_q == ST_IDLE) && (start || AUTO_START)) ||
                     ((state_q == ST_DONE) && start);
  assign is_marker = (rom_data == LCD_DLY_MARKER);
  assign hs        = valid_q && cmd_ready;

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (launch) begin
      cnt_load = 1'b1;
      cnt_val  = PWR_LD;
    end else if ((state_q == ST_FETCH) && is_marker) begin
      cnt_load = 1'b1;
      cnt_val  = LONG_LD;
    end else if ((state_q == ST_SEND) && hs) begin
      cnt_load = 1'b1;
      cnt_val  = GAP_LD;
    end
  end

  lcd_dly_cnt #(.DLY_W(DLY_W)) u_dly (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state_q <= ST_PWR_WAIT;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_PWR_WAIT: begin
          if (cnt_zero) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          // The marker byte is never transmitted; it only buys a long wait.
          if (is_marker) begin
            state_q <= ST_LWAIT;
          end else begin
            byte_q  <= rom_data;
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (hs) begin
            valid_q <= 1'b0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP, ST_LWAIT: begin
          if (cnt_zero) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign cmd_byte  = byte_q;
  assign cmd_valid = valid_q;
  assign busy      = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq: one auto-start and one manual-start instance.
module tb_lcd_init_seq;

  localparam int N = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, ready, sel;
  logic [7:0] rom [16];
  logic [3:0] addr_a, addr_b;
  logic [7:0] rd_a, rd_b, byte_a, byte_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  assign rd_a = rom[addr_a];
  assign rd_b = rom[addr_b];

  lcd_init_seq #(.N_INST(N), .PWR_DELAY(4), .GAP_DELAY(2), .LONG_DELAY(5),
                 .DLY_W(24), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(addr_a), .rom_data(rd_a),
    .cmd_valid(valid_a), .cmd_ready(ready), .cmd_byte(byte_a),
    .busy(busy_a), .init_done(done_a));

  lcd_init_seq #(.N_INST(N), .PWR_DELAY(4), .GAP_DELAY(2), .LONG_DELAY(5),
                 .DLY_W(24), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(addr_b), .rom_data(rd_b),
    .cmd_valid(valid_b), .cmd_ready(ready), .cmd_byte(byte_b),
    .busy(busy_b), .init_done(done_b));

  logic       m_valid, m_busy, m_done;
  logic [7:0] m_byte;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_byte  = sel ? byte_b  : byte_a;

  int tests = 0;
  int fails = 0;

  // Handshake log; rel counts cycles from the first busy cycle (rel 0).
  int         rel = 0;
  logic       busy_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] hs_byte [$];
  int         hs_rel  [$];
  int         done_rel = -1, busy_fall_rel = -1, ff_sent = 0;
  bit         done_seen = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (m_busy && !busy_prev) rel = 0;
    else                      rel = rel + 1;
    if (m_valid && ready) begin
      hs_byte.push_back(m_byte);
      hs_rel.push_back(rel);
    end
    if (m_valid && m_byte == 8'hFF) ff_sent++;
    if (m_done && !done_prev) begin
      done_seen = 1'b1;
      done_rel  = rel;
    end
    if (!m_busy && busy_prev) busy_fall_rel = rel;
    busy_prev = m_busy;
    done_prev = m_done;
  end

  typedef struct {
    logic [7:0] rom_val;
    logic [7:0] exp_byte;
    int         exp_rel;
  } vec_t;
  vec_t tbl [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_byte.delete();
    hs_rel.delete();
    done_seen     = 1'b0;
    done_rel      = -1;
    busy_fall_rel = -1;
    ff_sent       = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 400 && !done_seen; k++) tick();
    chk({nm, " done_in_budget"}, 32'(done_seen), 32'd1);
  endtask

  task automatic pulse_start_a(input string nm);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({nm, " restart_done_low"}, 32'(done_a), 32'd0);
    chk({nm, " restart_addr0"},    32'(addr_a), 32'd0);
    chk({nm, " restart_busy"},     32'(busy_a), 32'd1);
  endtask

  task automatic check_table(input string nm, input int done_exp,
                             input int bp_idx, input int bp_extra);
    chk({nm, " hs_count"}, 32'(hs_byte.size()), 32'(N));
    for (int i = 0; i < N; i++) begin
      if (i < hs_byte.size()) begin
        chk($sformatf("%s byte%0d", nm, i), 32'(hs_byte[i]), 32'(tbl[i].exp_byte));
        chk($sformatf("%s rel%0d", nm, i), 32'(hs_rel[i]),
            32'(tbl[i].exp_rel + ((i >= bp_idx) ? bp_extra : 0)));
      end
    end
    chk({nm, " done_rel"},      32'(done_rel),      32'(done_exp));
    chk({nm, " busy_fall_rel"}, 32'(busy_fall_rel), 32'(done_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4_rel [13];
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1; sel = 1'b0;

    // PWR=4, GAP=2: handshake i at 4+1+4*i cycles after busy rises; done at 60.
    tbl = '{'{8'h01, 8'h01,  5}, '{8'h11, 8'h11,  9}, '{8'h21, 8'h21, 13},
            '{8'h31, 8'h31, 17}, '{8'h41, 8'h41, 21}, '{8'h51, 8'h51, 25},
            '{8'h61, 8'h61, 29}, '{8'h71, 8'h71, 33}, '{8'h81, 8'h81, 37},
            '{8'h91, 8'h91, 41}, '{8'hA1, 8'hA1, 45}, '{8'hB1, 8'hB1, 49},
            '{8'hC1, 8'hC1, 53}, '{8'hD1, 8'hD1, 57}};
    for (int i = 0; i < N; i++) rom[i] = tbl[i].rom_val;
    rom[14] = 8'h00;
    rom[15] = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst addr",  32'(addr_a),  32'd0);
    chk("rst byte",  32'(byte_a),  32'd0);
    chk("rst valid", 32'(valid_a), 32'd0);
    chk("rst busy",  32'(busy_a),  32'd0);
    chk("rst done",  32'(done_a),  32'd0);
    chk("rst b busy", 32'(busy_b), 32'd0);

    // R1: auto start after reset release
    clear_log();
    rst = 1'b0;
    wait_done("r1");
    check_table("r1", 60, N, 0);
    tick(); tick();
    chk("r1 done_held", 32'(done_a), 32'd1);
    chk("r1 addr_last", 32'(addr_a), 32'd13);
    chk("r1 b_idle",    32'(busy_b), 32'd0);

    // R2: backpressure for 7 cycles on entry 3
    clear_log();
    pulse_start_a("r2");
    for (int k = 0; k < 100 && addr_a != 4'd3; k++) tick();
    chk("r2 reach_addr3", 32'(addr_a), 32'd3);
    ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("r2 bp_valid%0d", k), 32'(valid_a), 32'd1);
      chk($sformatf("r2 bp_byte%0d", k),  32'(byte_a),  32'h31);
      chk($sformatf("r2 bp_addr%0d", k),  32'(addr_a),  32'd3);
    end
    tick();
    chk("r2 bp_valid_last", 32'(valid_a), 32'd1);
    ready = 1'b1;
    wait_done("r2");
    check_table("r2", 67, 3, 7);

    // R3: start while busy at cycle 20 is ignored
    clear_log();
    pulse_start_a("r3");
    for (int k = 0; k < 20; k++) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("r3 busy_kept", 32'(busy_a), 32'd1);
    wait_done("r3");
    check_table("r3", 60, N, 0);

    // R4: delay marker at entry 5
    rom[5] = 8'hFF;
    exp4_rel = '{5, 9, 13, 17, 21, 31, 35, 39, 43, 47, 51, 55, 59};
    clear_log();
    pulse_start_a("r4");
    wait_done("r4");
    chk("r4 hs_count", 32'(hs_byte.size()), 32'd13);
    for (int j = 0; j < 13; j++) begin
      if (j < hs_byte.size()) begin
        chk($sformatf("r4 byte%0d", j), 32'(hs_byte[j]), 32'(tbl[(j < 5) ? j : j + 1].exp_byte));
        chk($sformatf("r4 rel%0d", j),  32'(hs_rel[j]),  32'(exp4_rel[j]));
      end
    end
    chk("r4 marker_not_sent", 32'(ff_sent),  32'd0);
    chk("r4 done_rel",        32'(done_rel), 32'd62);
    rom[5] = tbl[5].rom_val;

    // R5: asynchronous reset during SEND of entry 8
    clear_log();
    pulse_start_a("r5");
    for (int k = 0; k < 100 && !(addr_a == 4'd8 && valid_a); k++) tick();
    chk("r5 reach_send8", 32'(valid_a && addr_a == 4'd8), 32'd1);
    rst = 1'b1;
    #1;
    chk("r5 async_valid", 32'(valid_a), 32'd0);
    chk("r5 async_addr",  32'(addr_a),  32'd0);
    chk("r5 async_busy",  32'(busy_a),  32'd0);
    chk("r5 async_done",  32'(done_a),  32'd0);
    tick(); tick();
    clear_log();
    rst = 1'b0;
    wait_done("r5");
    check_table("r5", 60, N, 0);

    // R6: manual-start instance stays idle, then runs once on start
    sel = 1'b1;
    tick(); tick();
    chk("r6 idle_busy",  32'(busy_b),  32'd0);
    chk("r6 idle_addr",  32'(addr_b),  32'd0);
    chk("r6 idle_valid", 32'(valid_b), 32'd0);
    chk("r6 idle_done",  32'(done_b),  32'd0);
    clear_log();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("r6 started", 32'(busy_b), 32'd1);
    wait_done("r6");
    check_table("r6", 60, N, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
